// File: rtl/prog_instr_mem_if.sv
// Fetch and byte-serial load bus of the IF-stage instruction memory.
// master = IF stage plus boot loader, slave = the memory.
interface prog_instr_mem_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_en;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [7:0]        load_byte;
  logic              load_byte_valid;
  logic              load_done;
  logic              load_busy;
  logic [ADDR_W:0]   load_count;
  logic              load_err;

  modport master (
    output fetch_addr, fetch_en, load_start, load_base, load_byte, load_byte_valid, load_done,
    input  instr, instr_valid, load_busy, load_count, load_err
  );

  modport slave (
    input  fetch_addr, fetch_en, load_start, load_base, load_byte, load_byte_valid, load_done,
    output instr, instr_valid, load_busy, load_count, load_err
  );
endinterface

// File: rtl/prog_instr_mem.sv
// Run-time loadable instruction memory: registered fetch (1-cycle latency, fetch_en=0 holds the output),
// byte-serial loader; no backpressure, fetches return NOP while a load is in progress.
module prog_instr_mem #(
  parameter int               ADDR_W     = 9,
  parameter int               DEPTH      = 512,
  parameter int               DATA_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter bit               BIG_ENDIAN = 1'b1
) (
  input logic       clk,
  input logic       reset,
  prog_instr_mem_if.slave bus
);
  localparam int BPW    = DATA_W / 8;
  localparam int IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  typedef enum logic {RUN, LOAD} state_t;

  state_t            state_q, state_nxt;
  logic [ADDR_W:0]   ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic [DATA_W-1:0] asm_q, asm_nxt;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              err_q;

  logic byte_take;
  logic word_done;
  logic ptr_ok;
  logic fetch_ok;
  logic done_take;
  logic partial_err;

  // Contents survive reset so a reset cannot wipe a freshly booted program.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    asm_nxt     = asm_q;
    byte_take   = 1'b0;
    word_done   = 1'b0;
    done_take   = 1'b0;
    partial_err = 1'b0;
    ptr_ok      = (ptr_q < DEPTH_L);
    fetch_ok    = ({1'b0, bus.fetch_addr} < DEPTH_L);

    if (BIG_ENDIAN) begin
      asm_nxt = (asm_q << 8) | DATA_W'(bus.load_byte);
    end else begin
      asm_nxt = (asm_q >> 8) | (DATA_W'(bus.load_byte) << (DATA_W - 8));
    end

    unique case (state_q)
      RUN: begin
        if (bus.load_start) state_nxt = LOAD;
      end
      LOAD: begin
        // A restart outranks both a same-cycle byte and a same-cycle done.
        if (!bus.load_start) begin
          byte_take = bus.load_byte_valid;
          word_done = byte_take && (idx_q == LAST_IDX);
          if (word_done)      idx_nxt = '0;
          else if (byte_take) idx_nxt = idx_q + 1'b1;
          if (bus.load_done) begin
            done_take   = 1'b1;
            partial_err = (idx_nxt != '0);
            state_nxt   = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (state_q == LOAD || bus.load_start) begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
      end else if (bus.fetch_en) begin
        instr_q <= fetch_ok ? mem[bus.fetch_addr[MEM_AW-1:0]] : NOP_WORD;
        valid_q <= 1'b1;
      end

      if (bus.load_start) begin
        ptr_q   <= {1'b0, bus.load_base};
        idx_q   <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (state_q == LOAD) begin
        if (byte_take) asm_q <= asm_nxt;
        idx_q <= done_take ? '0 : idx_nxt;
        if (word_done) begin
          if (ptr_ok) begin
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q + 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        if (partial_err) err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_done && ptr_ok) mem[ptr_q[MEM_AW-1:0]] <= asm_nxt;
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.load_busy   = (state_q == LOAD);
  assign bus.load_count  = count_q;
  assign bus.load_err    = err_q;
endmodule

// File: tb/tb_prog_instr_mem.sv
// Directed bench: dut_a is the default big-endian 512-word memory, dut_b a little-endian 4-word one.
// Both share fetch and load data; each has its own load_start so only the addressed one loads.
module tb_prog_instr_mem;
  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] fetch_addr;
  logic       fetch_en;
  logic       start_a, start_b;
  logic [8:0] load_base;
  logic [7:0] load_byte;
  logic       load_byte_valid;
  logic       load_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prog_instr_mem_if #(.ADDR_W(9), .DATA_W(32)) bus_a ();
  prog_instr_mem_if #(.ADDR_W(9), .DATA_W(32)) bus_b ();

  assign bus_a.fetch_addr      = fetch_addr;
  assign bus_a.fetch_en        = fetch_en;
  assign bus_a.load_start      = start_a;
  assign bus_a.load_base       = load_base;
  assign bus_a.load_byte       = load_byte;
  assign bus_a.load_byte_valid = load_byte_valid;
  assign bus_a.load_done       = load_done;

  assign bus_b.fetch_addr      = fetch_addr;
  assign bus_b.fetch_en        = fetch_en;
  assign bus_b.load_start      = start_b;
  assign bus_b.load_base       = load_base;
  assign bus_b.load_byte       = load_byte;
  assign bus_b.load_byte_valid = load_byte_valid;
  assign bus_b.load_done       = load_done;

  prog_instr_mem #(
    .ADDR_W(9), .DEPTH(512), .DATA_W(32), .NOP_WORD(32'h00000000), .BIG_ENDIAN(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );

  prog_instr_mem #(
    .ADDR_W(9), .DEPTH(4), .DATA_W(32), .NOP_WORD(32'h00000000), .BIG_ENDIAN(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic start(input bit to_b, input logic [8:0] base);
    load_base = base;
    if (to_b) start_b = 1'b1;
    else      start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    load_byte       = d;
    load_byte_valid = 1'b1;
    step();
    load_byte_valid = 1'b0;
  endtask

  task automatic end_load();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
  endtask

  task automatic fetch(input logic [8:0] a);
    fetch_addr = a;
    fetch_en   = 1'b1;
    step();
  endtask

  logic [7:0] be_prog [12] = '{8'h8d, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10,
                               8'h20, 8'h21, 8'h21, 8'h05, 8'h00, 8'h04};

  initial begin
    reset = 1'b1; fetch_addr = '0; fetch_en = 1'b0; start_a = 1'b0; start_b = 1'b0;
    load_base = '0; load_byte = '0; load_byte_valid = 1'b0; load_done = 1'b0;
    step(); step();
    chk("rst_instr", bus_a.instr, 64'h0);
    chk("rst_valid", bus_a.instr_valid, 64'h0);
    chk("rst_busy",  bus_a.load_busy, 64'h0);
    chk("rst_count", bus_a.load_count, 64'h0);
    chk("rst_err",   bus_a.load_err, 64'h0);
    reset = 1'b0;
    step();

    // Big-endian program with fetch_en held high: fetches must be ignored in LOAD.
    fetch_en = 1'b1;
    start(1'b0, 9'd0);
    chk("be_busy_on",  bus_a.load_busy, 64'h1);
    chk("be_valid_off", bus_a.instr_valid, 64'h0);
    foreach (be_prog[i]) send(be_prog[i]);
    chk("be_count", bus_a.load_count, 64'd3);
    chk("be_valid_load", bus_a.instr_valid, 64'h0);
    end_load();
    chk("be_busy_off", bus_a.load_busy, 64'h0);
    chk("be_err", bus_a.load_err, 64'h0);
    chk("be_exit_valid", bus_a.instr_valid, 64'h0);
    fetch(9'd1);
    chk("be_w1", bus_a.instr, 64'h00102021);
    chk("be_w1_valid", bus_a.instr_valid, 64'h1);
    fetch(9'd0);
    chk("be_w0", bus_a.instr, 64'h8d100000);

    // Stall: outputs hold while the address moves.
    fetch_en = 1'b0; fetch_addr = 9'd2; step();
    chk("stall_a2", bus_a.instr, 64'h8d100000);
    fetch_addr = 9'd1; step();
    chk("stall_a1", bus_a.instr, 64'h8d100000);
    chk("stall_valid", bus_a.instr_valid, 64'h1);
    fetch(9'd2);
    chk("be_w2", bus_a.instr, 64'h21050004);

    // Six bytes, done coincident with the sixth: one word written plus a partial error.
    start(1'b0, 9'd5);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    load_byte = 8'h66; load_byte_valid = 1'b1; load_done = 1'b1;
    step();
    load_byte_valid = 1'b0; load_done = 1'b0;
    chk("part_busy", bus_a.load_busy, 64'h0);
    chk("part_count", bus_a.load_count, 64'd1);
    chk("part_err", bus_a.load_err, 64'h1);
    fetch(9'd5);
    chk("part_w5", bus_a.instr, 64'h11223344);
    chk("part_err_hold", bus_a.load_err, 64'h1);
    chk("part_count_hold", bus_a.load_count, 64'd1);

    // Reset after five bytes: outputs clear at once, the completed word survives.
    start(1'b0, 9'd8);
    send(8'haa); send(8'hbb); send(8'hcc); send(8'hdd); send(8'hee);
    chk("mid_count_pre", bus_a.load_count, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_instr", bus_a.instr, 64'h0);
    chk("mid_valid", bus_a.instr_valid, 64'h0);
    chk("mid_busy", bus_a.load_busy, 64'h0);
    chk("mid_count", bus_a.load_count, 64'h0);
    chk("mid_err", bus_a.load_err, 64'h0);
    step();
    reset = 1'b0;
    step();
    fetch(9'd8);
    chk("mid_w8", bus_a.instr, 64'haabbccdd);
    chk("mid_busy_after", bus_a.load_busy, 64'h0);

    // Little-endian load.
    start(1'b1, 9'd0);
    send(8'h00); send(8'h00); send(8'h10); send(8'h8d);
    end_load();
    chk("le_count", bus_b.load_count, 64'd1);
    chk("le_err", bus_b.load_err, 64'h0);
    fetch(9'd0);
    chk("le_w0", bus_b.instr, 64'h8d100000);

    // Restart with a byte and done in the same cycle: restart wins, byte dropped.
    start(1'b1, 9'd1);
    send(8'h11); send(8'h22);
    load_base = 9'd2; start_b = 1'b1; load_byte = 8'h99; load_byte_valid = 1'b1; load_done = 1'b1;
    step();
    start_b = 1'b0; load_byte_valid = 1'b0; load_done = 1'b0;
    chk("rs_busy", bus_b.load_busy, 64'h1);
    chk("rs_count", bus_b.load_count, 64'd0);
    send(8'haa); send(8'hbb); send(8'hcc); send(8'hdd);
    end_load();
    chk("rs_count_end", bus_b.load_count, 64'd1);
    chk("rs_err", bus_b.load_err, 64'h0);
    fetch(9'd2);
    chk("rs_w2", bus_b.instr, 64'hddccbbaa);
    fetch(9'd1);
    chk("rs_w1_untouched", bus_b.instr, 64'h0);

    // Overflow past the last word of a 4-word memory.
    start(1'b1, 9'd3);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("ov_count1", bus_b.load_count, 64'd1);
    chk("ov_err0", bus_b.load_err, 64'h0);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("ov_count2", bus_b.load_count, 64'd1);
    chk("ov_err1", bus_b.load_err, 64'h1);
    end_load();
    fetch(9'd3);
    chk("ov_w3", bus_b.instr, 64'h04030201);
    fetch(9'd4);
    chk("oor_instr", bus_b.instr, 64'h0);
    chk("oor_valid", bus_b.instr_valid, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
